// File: rtl/lut_table_loader_if.sv
// Stream-load and lookup bus of the runtime-loadable neuron truth table.
// The master side is the layer config / neuron datapath; the slave side is the loader.
interface lut_table_loader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int PACK     = 4
) ();
    logic                     start;
    logic                     s_valid;
    logic                     s_ready;
    logic [PACK*OUT_BITS-1:0] s_data;
    logic                     loaded;
    logic [15:0]              checksum;
    logic                     q_valid;
    logic [IN_BITS-1:0]       q_code;
    logic                     r_valid;
    logic [OUT_BITS-1:0]      r_data;

    modport master (
        output start, s_valid, s_data, q_valid, q_code,
        input  s_ready, loaded, checksum, r_valid, r_data
    );

    modport slave (
        input  start, s_valid, s_data, q_valid, q_code,
        output s_ready, loaded, checksum, r_valid, r_data
    );
endinterface

// File: rtl/lut_table_loader.sv
// Runtime-loadable neuron truth table: fills a 2**IN_BITS x OUT_BITS RAM from a packed
// stream, keeps a checksum of the loaded entries, then serves registered lookups.
module lut_table_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int PACK     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_table_loader_if.slave bus
);
    localparam int DEPTH = 2 ** IN_BITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IN_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [15:0]         checksum_q, checksum_d;
    logic [15:0]         word_sum;
    logic                r_valid_q;
    logic [OUT_BITS-1:0] r_data_q;
    logic                accept;
    logic                wr_en;
    logic                last_word;
    logic                loaded;

    // No reset on the table: contents are meaningless until loaded is set.
    logic [OUT_BITS-1:0] mem [DEPTH];

    assign loaded    = (state_q == READY);
    assign accept    = bus.s_valid && (state_q == LOAD);
    // A start in the same cycle as a handshake discards that word.
    assign wr_en     = accept && !bus.start;
    assign last_word = (wr_addr_q == IN_BITS'(DEPTH - PACK));

    // Sum of the entries in the current stream word, zero-extended.
    always_comb begin
        word_sum = '0;
        for (int k = 0; k < PACK; k++) begin
            word_sum = word_sum + 16'(bus.s_data[k*OUT_BITS +: OUT_BITS]);
        end
    end

    // Load sequencing: start (re)enters LOAD, the word covering the last address ends it.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        checksum_d = checksum_q;
        if (bus.start) begin
            state_d    = LOAD;
            wr_addr_d  = '0;
            checksum_d = '0;
        end else if (wr_en) begin
            wr_addr_d  = wr_addr_q + IN_BITS'(PACK);
            checksum_d = checksum_q + word_sum;
            if (last_word) begin
                state_d = READY;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            checksum_q <= checksum_d;
        end
    end

    // Table write port: all PACK entries of an accepted word land in one cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < PACK; k++) begin
                mem[wr_addr_q + IN_BITS'(k)] <= bus.s_data[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Registered lookup; r_data holds its last value when a lookup is refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= bus.q_valid && loaded;
            if (bus.q_valid && loaded) begin
                r_data_q <= mem[bus.q_code];
            end
        end
    end

    assign bus.s_ready  = (state_q == LOAD);
    assign bus.loaded   = loaded;
    assign bus.checksum = checksum_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
endmodule

// File: tb/tb_lut_table_loader.sv
// Self-checking bench for lut_table_loader: reference table model plus a lookup scoreboard.
module tb_lut_table_loader;
    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 2;
    localparam int PACK     = 4;
    localparam int DEPTH    = 256;
    localparam int WORDS    = 64;

    typedef struct {
        logic [7:0] code;
        logic       v;
        logic [1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lut_table_loader_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .PACK(PACK)) bus ();

    lut_table_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .PACK(PACK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [1:0]  ref_mem [DEPTH];
    logic [15:0] ref_sum = '0;
    int          ref_addr = 0;
    bit          ref_loaded = 1'b0;
    logic [1:0]  ref_rdata = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_load();
        ref_sum    = '0;
        ref_addr   = 0;
        ref_loaded = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        model_clear_load();
        checks++;
        if (bus.s_ready !== 1'b1 || bus.loaded !== 1'b0) begin
            errors++;
            $display("FAIL start_to_load: s_ready=%b loaded=%b, expected 1 0", bus.s_ready,
                     bus.loaded);
        end
    endtask

    // Push the expected result of a lookup issued this cycle.
    task automatic issue(input logic [7:0] code);
        exp_t e;
        bus.q_valid = 1'b1;
        bus.q_code  = code;
        e.code = code;
        if (ref_loaded) begin
            e.v = 1'b1;
            e.d = ref_mem[code];
            ref_rdata = e.d;
        end else begin
            e.v = 1'b0;
            e.d = ref_rdata;
        end
        sb.push_back(e);
    endtask

    // Offer one word and wait (bounded) for the handshake.
    task automatic send_word(input logic [7:0] d, input bit last);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!acc && n < 16) begin
            acc = bus.s_ready;
            if (last && acc) begin
                checks++;
                if (bus.loaded !== 1'b0) begin
                    errors++;
                    $display("FAIL loaded_early: loaded=%b before final word, expected 0",
                             bus.loaded);
                end
            end
            tick();
            n++;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: word %02h not accepted, expected accept", d);
        end else begin
            for (int k = 0; k < PACK; k++) begin
                ref_mem[(ref_addr + k) % DEPTH] = d[k*OUT_BITS +: OUT_BITS];
                ref_sum = ref_sum + 16'(d[k*OUT_BITS +: OUT_BITS]);
            end
            ref_addr += PACK;
            if (ref_addr == DEPTH) ref_loaded = 1'b1;
        end
    endtask

    task automatic load_table(input bit do_start, input bit rnd_data, input logic [7:0] fixed,
                              input bit rnd_valid);
        logic [7:0] d;
        if (do_start) pulse_start();
        for (int w = 0; w < WORDS; w++) begin
            if (rnd_valid) repeat ($urandom_range(0, 2)) tick();
            d = rnd_data ? 8'($urandom) : fixed;
            send_word(d, w == WORDS - 1);
        end
        checks++;
        if (bus.loaded !== 1'b1 || bus.s_ready !== 1'b0 || bus.checksum !== ref_sum) begin
            errors++;
            $display("FAIL load_done: loaded=%b s_ready=%b checksum=%0d, expected 1 0 %0d",
                     bus.loaded, bus.s_ready, bus.checksum, ref_sum);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.s_ready !== 1'b0 || bus.loaded !== 1'b0 || bus.checksum !== 16'd0 ||
            bus.r_valid !== 1'b0 || bus.r_data !== 2'b00) begin
            errors++;
            $display("FAIL reset_values: s_ready=%b loaded=%b checksum=%0d r_valid=%b r_data=%b, expected all 0",
                     bus.s_ready, bus.loaded, bus.checksum, bus.r_valid, bus.r_data);
        end
        rst_n = 1'b1;
        tick();
        // Lookups before any load must be refused.
        for (int i = 0; i < 3; i++) begin
            issue(8'(i * 37));
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.r_valid !== e.v || bus.r_data !== e.d) begin
                errors++;
                $display("FAIL reset_lookup code=%02h: got v=%b d=%b, expected v=%b d=%b",
                         e.code, bus.r_valid, bus.r_data, e.v, e.d);
            end
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic test_zero_load();
        exp_t e;
        logic [7:0] codes [3];
        codes[0] = 8'h00;
        codes[1] = 8'h55;
        codes[2] = 8'hFF;
        load_table(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.checksum !== 16'd0) begin
            errors++;
            $display("FAIL zero_checksum: checksum=%0d, expected 0", bus.checksum);
        end
        for (int i = 0; i < 3; i++) begin
            issue(codes[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.r_valid !== 1'b1 || bus.r_data !== 2'b00 || bus.r_data !== e.d) begin
                errors++;
                $display("FAIL zero_lookup code=%02h: got v=%b d=%b, expected v=1 d=00",
                         e.code, bus.r_valid, bus.r_data);
            end
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic test_ramp();
        exp_t e;
        load_table(1'b1, 1'b0, 8'hE4, 1'b0);
        checks++;
        if (bus.checksum !== 16'd384) begin
            errors++;
            $display("FAIL ramp_checksum: checksum=%0d, expected 384", bus.checksum);
        end
        issue(8'h7B);
        bus.q_valid = 1'b1;
        tick();
        bus.q_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.r_valid !== 1'b1 || bus.r_data !== 2'b11 || e.d !== 2'b11) begin
            errors++;
            $display("FAIL ramp_lookup_7b: got v=%b d=%b, expected v=1 d=11", bus.r_valid,
                     bus.r_data);
        end
        tick();
        checks++;
        if (bus.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_idle: r_valid=%b with no request, expected 0", bus.r_valid);
        end
        // Back-to-back lookups on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            issue(8'(i));
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.r_valid !== 1'b1 || bus.r_data !== 2'(i) || bus.r_data !== e.d) begin
                errors++;
                $display("FAIL back_to_back code=%02h: got v=%b d=%b, expected v=1 d=%b",
                         e.code, bus.r_valid, bus.r_data, 2'(i));
            end
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic test_lookup_unloaded();
        exp_t e;
        pulse_start();
        for (int w = 0; w < 10; w++) send_word(8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(8'($urandom));
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.r_valid !== 1'b0 || bus.r_data !== e.d) begin
                errors++;
                $display("FAIL midload_lookup code=%02h: got v=%b d=%b, expected v=0 d=%b",
                         e.code, bus.r_valid, bus.r_data, e.d);
            end
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic test_random_valid();
        exp_t e;
        load_table(1'b1, 1'b1, 8'h00, 1'b1);
        // Words offered after the load completes must be ignored.
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        repeat (3) tick();
        bus.s_valid = 1'b0;
        checks++;
        if (bus.checksum !== ref_sum || bus.s_ready !== 1'b0 || bus.loaded !== 1'b1) begin
            errors++;
            $display("FAIL no_extra_accept: checksum=%0d s_ready=%b loaded=%b, expected %0d 0 1",
                     bus.checksum, bus.s_ready, bus.loaded, ref_sum);
        end
        for (int i = 0; i < DEPTH; i++) begin
            issue(8'(i));
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.r_valid !== e.v || bus.r_data !== e.d) begin
                errors++;
                $display("FAIL random_table code=%02h: got v=%b d=%b, expected v=%b d=%b",
                         e.code, bus.r_valid, bus.r_data, e.v, e.d);
            end
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic test_restart();
        exp_t e;
        pulse_start();
        for (int w = 0; w < 29; w++) send_word(8'($urandom), 1'b0);
        // 30th word coincides with start and must be dropped.
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        model_clear_load();
        checks++;
        if (bus.checksum !== 16'd0 || bus.s_ready !== 1'b1 || bus.loaded !== 1'b0) begin
            errors++;
            $display("FAIL restart_drop: checksum=%0d s_ready=%b loaded=%b, expected 0 1 0",
                     bus.checksum, bus.s_ready, bus.loaded);
        end
        load_table(1'b0, 1'b0, 8'hFF, 1'b0);
        checks++;
        if (bus.checksum !== 16'd768) begin
            errors++;
            $display("FAIL restart_checksum: checksum=%0d, expected 768", bus.checksum);
        end
        for (int i = 0; i < DEPTH; i++) begin
            issue(8'(i));
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.r_valid !== 1'b1 || bus.r_data !== 2'b11 || e.d !== 2'b11) begin
                errors++;
                $display("FAIL restart_table code=%02h: got v=%b d=%b, expected v=1 d=11",
                         e.code, bus.r_valid, bus.r_data);
            end
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic test_reset_midload();
        exp_t e;
        pulse_start();
        for (int w = 0; w < 20; w++) send_word(8'hE4, 1'b0);
        checks++;
        if (bus.checksum !== 16'd120 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: checksum=%0d s_ready=%b, expected 120 1", bus.checksum,
                     bus.s_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0 || bus.loaded !== 1'b0 || bus.checksum !== 16'd0 ||
            bus.r_valid !== 1'b0 || bus.r_data !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: s_ready=%b loaded=%b checksum=%0d r_valid=%b r_data=%b, expected all 0",
                     bus.s_ready, bus.loaded, bus.checksum, bus.r_valid, bus.r_data);
        end
        tick();
        rst_n = 1'b1;
        model_clear_load();
        ref_rdata = '0;
        tick();
        load_table(1'b1, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            issue(8'($urandom));
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.r_valid !== e.v || bus.r_data !== e.d) begin
                errors++;
                $display("FAIL post_reset_table code=%02h: got v=%b d=%b, expected v=%b d=%b",
                         e.code, bus.r_valid, bus.r_data, e.v, e.d);
            end
        end
        bus.q_valid = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.q_valid = 1'b0;
        bus.q_code  = '0;
        test_reset();
        test_zero_load();
        test_ramp();
        test_lookup_unloaded();
        test_random_valid();
        test_restart();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
